counter_xn: RTL and testbench
=============================

COUNTER_XN -- requirements
Module: counter_xn

Interface
REQ-001 Parameter: CH, default 4, number of independent timer channels (legal 1..8).
REQ-002 Parameter: W, default 32, counter and reload width in bits (legal 8..32).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst as elsewhere in the codebase.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 we  in  1  bus write strobe, one cycle per write.
REQ-007 ch_sel  in  3  target channel; values >= CH SHALL be ignored on write and SHALL read as zero.
REQ-008 reg_sel  in  2  register select: 0 = reload, 1 = control, 2 = done-clear, 3 = reserved (write ignored).
REQ-009 wdata  in  32  write data; low W bits used for reload.
REQ-010 tick_en  in  CH  per-channel count strobe, one-cycle pulses from the divider.
REQ-011 rdata  out  W  current count of channel ch_sel (combinational from registers).
REQ-012 cnt_out  out  CH  per-channel timer output.
REQ-013 done  out  CH  sticky per-channel terminal-count flags.
REQ-014 irq  out  1  interrupt request.

Function
REQ-015 Each channel SHALL hold reload[W-1:0], count[W-1:0], ctrl[3:0] (bit0 = enable, bits2:1 = mode, bit3 = irq mask), out and done.
REQ-016 Reload write SHALL load both reload and count with wdata[W-1:0], clear that channel's out, and take effect at the same edge.
REQ-017 Control write SHALL load ctrl with wdata[3:0] without altering count.
REQ-018 Done-clear write SHALL clear done[i] for every i with wdata[i] = 1.
REQ-019 A channel SHALL count only on a cycle with enable = 1 and tick_en[i] = 1; count SHALL decrement by 1 when nonzero.
REQ-020 Terminal event: the channel SHALL reach terminal on a counted cycle where count == 0, with per-mode behaviour given below.
REQ-021 Mode 00 (one-shot): count holds 0, out <= 1, done <= 1, enable <= 0.
REQ-022 Mode 01 (auto-reload): count <= reload, out is a one-cycle pulse, done <= 1.
REQ-023 Mode 10 (square): count <= reload, out toggles, done <= 1.
REQ-024 Mode 11 SHALL behave exactly as mode 00.
REQ-025 Reload = 0: every counted cycle is a terminal event (auto-reload pulses each tick; square toggles each tick).
REQ-026 A bus write to a channel and a tick on that channel in the same cycle: the write SHALL win and the tick SHALL be dropped.
REQ-027 Done set and done-clear in the same cycle: set SHALL win.
REQ-028 Channels SHALL be fully independent; ticks on one channel SHALL never affect another.
REQ-029 Latency: rdata, cnt_out and done SHALL reflect an edge's update immediately after that edge (zero added pipeline).

Reset
REQ-030 On rst, all reload, count, ctrl, out and done SHALL be 0; rdata = 0, cnt_out = 0, done = 0, irq = 0 in the cycle after.
REQ-031 rst SHALL override a simultaneous we or tick_en and SHALL abort any count in progress.

Configuration
REQ-032 Macro COUNTER_XN_IRQ_EN: when defined, irq SHALL be registered as OR over i of (done[i] & ctrl[i][3]), one cycle after done or mask changes.
REQ-033 When COUNTER_XN_IRQ_EN is undefined, irq SHALL be constant 0, ctrl bit3 SHALL still be stored, and done behaviour SHALL be unchanged.

Verification
REQ-034 Reset: rst high 2 cycles during ticks -> all outputs 0, rdata = 0 for every ch_sel.
REQ-035 One-shot: ch0 reload = 3, ctrl = 0x1, tick every cycle -> rdata 2,1,0; cnt_out[0] = 1 and done[0] = 1 on 4th tick; enable cleared; further ticks leave rdata = 0.
REQ-036 Auto-reload: ch1 reload = 2, ctrl = 0x3, tick every cycle -> cnt_out[1] one-cycle pulse every 3 ticks; rdata sequence 2,1,0,2,1,0.
REQ-037 Square with reload = 0: ch2 ctrl = 0x5, tick every other cycle -> cnt_out[2] toggles on each tick.
REQ-038 Collision: reload write of 5 to ch0 with tick_en[0] = 1 in the same cycle -> rdata = 5 next cycle; done set plus clear in the same cycle -> done stays 1.
REQ-039 IRQ (macro on): ch3 one-shot with mask = 1 -> irq = 1 one cycle after done[3]; done-clear 0x8 -> irq = 0 next cycle; macro off -> irq stays 0 throughout.

Source files
------------

// File: rtl/counter_xn_if.sv
// Register-bus bundle for counter_xn: write strobe, channel/register select,
// write data and the combinational read-back of the selected count.
interface counter_xn_if #(
  parameter int W = 32
);
  logic         we;
  logic [2:0]   ch_sel;
  logic [1:0]   reg_sel;
  logic [31:0]  wdata;
  logic [W-1:0] rdata;

  modport master (
    output we, ch_sel, reg_sel, wdata,
    input  rdata
  );

  modport slave (
    input  we, ch_sel, reg_sel, wdata,
    output rdata
  );
endinterface

// File: rtl/counter_xn.sv
// CH independent down-counting timers (one-shot / auto-reload / square) with sticky done flags.
// Optional feature macro: COUNTER_XN_IRQ_EN enables the registered, masked interrupt output.
module counter_xn #(
  parameter int CH = 4,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  counter_xn_if.slave   bus,
  input  logic [CH-1:0] tick_en,
  output logic [CH-1:0] cnt_out,
  output logic [CH-1:0] done,
  output logic          irq
);

  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_SQUARE = 2'b10;

  logic [W-1:0]  w_count [CH];
  logic [CH-1:0] w_mask;
  logic [W-1:0]  w_rdata;
  logic          w_clr;

  // Done-clear is a block-wide write, but still needs an in-range channel select.
  assign w_clr = bus.we && (bus.reg_sel == 2'd2) && ({1'b0, bus.ch_sel} < 4'(CH));

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : gen_ch
      logic [W-1:0] r_reload;
      logic [W-1:0] r_count;
      logic [3:0]   r_ctrl;
      logic         r_out;
      logic         r_done;
      logic         w_hit;
      logic         w_wr_reload;
      logic         w_wr_ctrl;
      logic [1:0]   w_mode;

      assign w_hit       = bus.we && (bus.ch_sel == 3'(gi));
      assign w_wr_reload = w_hit && (bus.reg_sel == 2'd0);
      assign w_wr_ctrl   = w_hit && (bus.reg_sel == 2'd1);
      assign w_mode      = r_ctrl[2:1];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_reload <= '0;
          r_count  <= '0;
          r_ctrl   <= '0;
          r_out    <= 1'b0;
          r_done   <= 1'b0;
        end else begin
          if (w_clr && bus.wdata[gi]) begin
            r_done <= 1'b0;
          end
          if (w_mode == MODE_AUTO) begin
            r_out <= 1'b0;
          end
          // A register write to this channel wins over a tick in the same cycle.
          if (w_wr_reload) begin
            r_reload <= bus.wdata[W-1:0];
            r_count  <= bus.wdata[W-1:0];
            r_out    <= 1'b0;
          end else if (w_wr_ctrl) begin
            r_ctrl <= bus.wdata[3:0];
          end else if (r_ctrl[0] && tick_en[gi]) begin
            if (r_count != '0) begin
              r_count <= r_count - W'(1);
            end else begin
              r_done <= 1'b1;
              case (w_mode)
                MODE_AUTO: begin
                  r_count <= r_reload;
                  r_out   <= 1'b1;
                end
                MODE_SQUARE: begin
                  r_count <= r_reload;
                  r_out   <= ~r_out;
                end
                default: begin
                  r_out     <= 1'b1;
                  r_ctrl[0] <= 1'b0;
                end
              endcase
            end
          end
        end
      end

      assign w_count[gi] = r_count;
      assign w_mask[gi]  = r_ctrl[3];
      assign cnt_out[gi] = r_out;
      assign done[gi]    = r_done;
    end
  endgenerate

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < CH; i++) begin
      if (bus.ch_sel == 3'(i)) begin
        w_rdata = w_count[i];
      end
    end
  end

  assign bus.rdata = w_rdata;

`ifdef COUNTER_XN_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(done & w_mask);
    end
  end

  assign irq = r_irq;
`else
  // Mask bits are still stored so software sees consistent ctrl behaviour.
  logic w_unused_mask;
  assign w_unused_mask = ^w_mask;
  assign irq           = 1'b0;
`endif

endmodule

// File: tb/tb_counter_xn.sv
// Directed self-checking bench for counter_xn: reset, one-shot, auto-reload,
// square, write/tick and set/clear collisions, interrupt behaviour.
module tb_counter_xn;

  localparam int CH = 4;
  localparam int W  = 32;
`ifdef COUNTER_XN_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [CH-1:0] tick_en;
  logic [CH-1:0] cnt_out;
  logic [CH-1:0] done;
  logic          irq;
  int            checks;
  int            errors;

  counter_xn_if #(.W(W)) bus ();

  counter_xn #(.CH(CH), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .tick_en (tick_en),
    .cnt_out (cnt_out),
    .done    (done),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int rs, input logic [31:0] data);
    bus.we      = 1'b1;
    bus.ch_sel  = 3'(ch);
    bus.reg_sel = 2'(rs);
    bus.wdata   = data;
    cycle();
    bus.we = 1'b0;
    $display("WR ch=%0d reg=%0d data=%0h", ch, rs, data);
  endtask

  initial begin
    logic [W-1:0] exp_cnt [6];
    logic         exp_pls [6];
    exp_cnt = '{32'd1, 32'd0, 32'd2, 32'd1, 32'd0, 32'd2};
    exp_pls = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    checks = 0;
    errors = 0;

    // Reset held two cycles with ticks and a write active.
    rst         = 1'b1;
    tick_en     = '1;
    bus.we      = 1'b1;
    bus.ch_sel  = 3'd0;
    bus.reg_sel = 2'd0;
    bus.wdata   = 32'd7;
    cycle();
    cycle();
    check("rst_cnt_out", 32'(cnt_out), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    for (int s = 0; s < 8; s++) begin
      bus.ch_sel = 3'(s);
      #1;
      check($sformatf("rst_rdata_ch%0d", s), bus.rdata, 32'h0);
    end
    rst     = 1'b0;
    tick_en = '0;
    bus.we  = 1'b0;
    cycle();
    $display("RESET released");

    // One-shot on ch0, reload 3.
    wr(0, 0, 32'd3);
    bus.ch_sel = 3'd0;
    #1;
    check("os_load", bus.rdata, 32'd3);
    wr(0, 1, 32'h1);
    tick_en = 4'b0001;
    for (int t = 1; t <= 3; t++) begin
      cycle();
      check($sformatf("os_rdata_t%0d", t), bus.rdata, 32'(3 - t));
      check($sformatf("os_out_t%0d", t), 32'(cnt_out[0]), 32'h0);
    end
    cycle();
    $display("TICK ch0 terminal");
    check("os_term_rdata", bus.rdata, 32'h0);
    check("os_term_out", 32'(cnt_out[0]), 32'h1);
    check("os_term_done", 32'(done[0]), 32'h1);
    cycle();
    cycle();
    check("os_hold_rdata", bus.rdata, 32'h0);
    check("os_hold_out", 32'(cnt_out[0]), 32'h1);
    tick_en = '0;

    // Auto-reload on ch1, reload 2: pulse every third tick.
    wr(1, 0, 32'd2);
    wr(1, 1, 32'h3);
    bus.ch_sel = 3'd1;
    #1;
    check("ar_start", bus.rdata, 32'd2);
    tick_en = 4'b0010;
    for (int t = 0; t < 6; t++) begin
      cycle();
      $display("TICK ch1 #%0d rdata=%0d out=%0b", t, bus.rdata, cnt_out[1]);
      check($sformatf("ar_rdata_t%0d", t), bus.rdata, exp_cnt[t]);
      check($sformatf("ar_out_t%0d", t), 32'(cnt_out[1]), 32'(exp_pls[t]));
    end
    tick_en = '0;
    cycle();
    check("ar_pulse_end", 32'(cnt_out[1]), 32'h0);
    check("ar_done", 32'(done[1]), 32'h1);
    check("ar_indep_ch0", 32'(cnt_out[0]), 32'h1);

    // Square on ch2, reload 0, tick every other cycle.
    wr(2, 1, 32'h5);
    for (int t = 0; t < 4; t++) begin
      tick_en = (t % 2 == 0) ? 4'b0100 : 4'b0000;
      cycle();
      check($sformatf("sq_out_c%0d", t), 32'(cnt_out[2]), 32'((t == 0 || t == 1) ? 1 : 0));
    end
    tick_en = '0;
    check("sq_done", 32'(done[2]), 32'h1);

    // Reload write colliding with a tick on ch0.
    wr(0, 1, 32'h1);
    tick_en = 4'b0001;
    wr(0, 0, 32'd5);
    tick_en = '0;
    bus.ch_sel = 3'd0;
    #1;
    check("col_rdata", bus.rdata, 32'd5);
    check("col_out_clr", 32'(cnt_out[0]), 32'h0);

    // Done set on ch2 in the same cycle as its clear: set wins.
    tick_en = 4'b0100;
    wr(0, 2, 32'h4);
    tick_en = '0;
    check("col_done_set_wins", 32'(done[2]), 32'h1);
    wr(0, 2, 32'h4);
    check("done_clear", 32'(done[2]), 32'h0);
    check("done_clear_keep_ch1", 32'(done[1]), 32'h1);

    // Ignored writes: reserved register and out-of-range channel.
    wr(0, 3, 32'd9);
    bus.ch_sel = 3'd0;
    #1;
    check("rsvd_ignored", bus.rdata, 32'd5);
    wr(5, 0, 32'd9);
    bus.ch_sel = 3'd5;
    #1;
    check("oor_rdata", bus.rdata, 32'h0);

    // Masked one-shot on ch3 drives irq one cycle after done.
    wr(3, 0, 32'd1);
    wr(3, 1, 32'h9);
    tick_en = 4'b1000;
    cycle();
    check("irq_pre_done", 32'(done[3]), 32'h0);
    cycle();
    tick_en = '0;
    check("irq_done3", 32'(done[3]), 32'h1);
    check("irq_lag", 32'(irq), 32'h0);
    cycle();
    check("irq_set", 32'(irq), 32'(IRQ_ON));
    wr(3, 2, 32'h8);
    check("irq_done3_clr", 32'(done[3]), 32'h0);
    check("irq_still", 32'(irq), 32'(IRQ_ON));
    cycle();
    check("irq_clr", 32'(irq), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
